matmul_ctrl_module: RTL and testbench
=====================================

// Module: matmul_ctrl_module
// PURPOSE
//   Sequencer for the systolic matmul array. It latches the operation dimensions on go_i, then:
//   - clears the array (its internal feed counter and accumulators only reset through its reset pin);
//   - holds the array start for exactly the cycles the operation needs;
//   - captures and masks the result and overflow flags into stable output registers;
//   - reports busy/done/error.
//   Sits between the control/register block and matmul_matrix_module.
// PARAMETERS
//   DATA_WIDTH  8   operand element width; array result elements are 2*DATA_WIDTH
//   BUS_WIDTH   16  bus width; localparam MAX_DIM = BUS_WIDTH/DATA_WIDTH (max N,K,M)
// PORTS
//   clk_i        in   1                          single clock, rising edge
//   rst_i        in   1                          asynchronous, active-high reset
//   go_i         in   1                          start request, sampled each clock
//   n_dim_i      in   2                          N (rows of A), legal 1..MAX_DIM
//   k_dim_i      in   2                          K (cols A / rows B), legal 1..MAX_DIM
//   m_dim_i      in   2                          M (cols of B), legal 1..MAX_DIM
//   c_matrix_i   in   MAX_DIM*MAX_DIM*2*DW       raw array result bus
//   flags_i      in   MAX_DIM*MAX_DIM            raw array per-PE overflow flags
//   array_rst_no out  1                          to array rst_ni (active-low clear)
//   array_start_o out 1                          to array start_i
//   n_dim_o/k_dim_o/m_dim_o out 2 each           latched dims to array
//   c_result_o   out  MAX_DIM*MAX_DIM*2*DW       captured, masked result
//   flags_o      out  MAX_DIM*MAX_DIM            captured, masked overflow flags
//   busy_o       out  1                          high from go accept until done_o
//   done_o       out  1                          one-cycle pulse, results valid
//   err_o        out  1                          sticky illegal-dimension error
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 except array_rst_no.
//     array_rst_no = ~rst_i & (state!=CLEAR), so the array clears asynchronously with rst_i.
//   Element (row r, col c) lives at slot s = c*MAX_DIM + r: bits [s*2*DW +: 2*DW]; flag bit s.
//   FSM IDLE->CLEAR->RUN->CAPTURE->DONE->IDLE:
//   IDLE: go_i=1 with all dims in 1..MAX_DIM:
//     latch dims, busy_o<=1, err_o<=0, go to CLEAR.
//     go_i=1 with any dim 0 (or >MAX_DIM): err_o<=1, stay IDLE, array untouched.
//   CLEAR: exactly 1 cycle with array_rst_no=0; run counter cleared; next state RUN.
//   RUN: array_start_o=1 for exactly L = N+K+M+1 cycles; counter width >= clog2(3*MAX_DIM+2).
//     L covers the registered feed skew plus the PE pipeline.
//   CAPTURE: 1 cycle, array_start_o=0.
//     c_result_o <= c_matrix_i with every slot r>=N or c>=M forced to 0.
//     flags_o <= flags_i, same masking.
//   DONE: done_o=1 for one cycle, busy_o<=0; next IDLE.
//     c_result_o/flags_o hold until the next CAPTURE or reset.
//   Latency: go_i accepted at edge 0 -> done_o high in cycle L+3 (N=K=M=2: cycle 10).
//   go_i while busy_o=1 is ignored: no restart, no error, dims unchanged.
//   go_i in the DONE cycle is ignored; go_i is accepted again from the first IDLE cycle.
//   Dims at inputs may change after acceptance without effect.
//   rst_i mid-operation: immediate return to IDLE, busy_o/done_o/array_start_o=0,
//     c_result_o/flags_o/err_o=0. The next go_i after release runs normally.
// TESTING
//   1 N=K=M=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]], flags_o=0,
//     done_o in cycle 10, busy_o high cycles 1..9.
//   2 N=1,K=2,M=1, A row=[3,-2], B col=[4,5] -> slot0=2, slots1..3=0,
//     done_o in cycle 8 (L=5).
//   3 Back-to-back: test 1, then go with A=B=identity -> C=identity
//     (no stale accumulation, CLEAR observed as 1-cycle array_rst_no=0).
//   4 DW=8, N=K=M=2, A=B all -128 -> each in-range sum 32768 overflows 16b;
//     flags_o=4'b1111 as driven by the array.
//   5 k_dim_i=0 with go_i -> err_o=1, busy_o=0, array_start_o never high;
//     next legal go clears err_o.
//   6 rst_i pulsed in RUN cycle 4 -> all outputs 0 same cycle, array_rst_no low;
//     go_i pulse during busy ignored; fresh go after release gives test-1 result.

Source files
------------

// File: rtl/matmul_ctrl_module.sv
// Sequencer for the systolic matmul array: latches dimensions, clears the array,
// runs it for N+K+M+1 cycles, then captures a masked copy of the result and flags.
module matmul_ctrl_module #(
  parameter  int DATA_WIDTH = 8,
  parameter  int BUS_WIDTH  = 16,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int SLOTS      = MAX_DIM * MAX_DIM,
  localparam int EW         = 2 * DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  go_i,
  input  logic [1:0]            n_dim_i,
  input  logic [1:0]            k_dim_i,
  input  logic [1:0]            m_dim_i,
  input  logic [SLOTS*EW-1:0]   c_matrix_i,
  input  logic [SLOTS-1:0]      flags_i,
  output logic                  array_rst_no,
  output logic                  array_start_o,
  output logic [1:0]            n_dim_o,
  output logic [1:0]            k_dim_o,
  output logic [1:0]            m_dim_o,
  output logic [SLOTS*EW-1:0]   c_result_o,
  output logic [SLOTS-1:0]      flags_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(3 * MAX_DIM + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_last;
  logic [1:0]          r_n;
  logic [1:0]          r_k;
  logic [1:0]          r_m;
  logic                r_start;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [SLOTS*EW-1:0] r_c;
  logic [SLOTS-1:0]    r_f;

  logic                w_dims_ok;
  logic [SLOTS*EW-1:0] w_c_masked;
  logic [SLOTS-1:0]    w_f_masked;

  function automatic logic dim_ok(input logic [1:0] d);
    return (d != 2'd0) && (int'(d) <= MAX_DIM);
  endfunction

  assign w_dims_ok = dim_ok(n_dim_i) && dim_ok(k_dim_i) && dim_ok(m_dim_i);

  // Slot s holds element (row s%MAX_DIM, col s/MAX_DIM); rows >= N and cols >= M are zeroed.
  always_comb begin
    w_c_masked = c_matrix_i;
    w_f_masked = flags_i;
    for (int s = 0; s < SLOTS; s++) begin
      if ((s % MAX_DIM) >= int'(r_n) || (s / MAX_DIM) >= int'(r_m)) begin
        w_c_masked[s*EW +: EW] = '0;
        w_f_masked[s]          = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= '0;
      r_n     <= 2'd0;
      r_k     <= 2'd0;
      r_m     <= 2'd0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_c     <= '0;
      r_f     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go_i) begin
            if (w_dims_ok) begin
              r_n     <= n_dim_i;
              r_k     <= k_dim_i;
              r_m     <= m_dim_i;
              // Counter runs 0..N+K+M, i.e. N+K+M+1 start cycles.
              r_last  <= CNT_W'(n_dim_i) + CNT_W'(k_dim_i) + CNT_W'(m_dim_i);
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
              r_state <= S_CLEAR;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_cnt   <= '0;
          r_start <= 1'b1;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_cnt == r_last) begin
            r_start <= 1'b0;
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          r_c     <= w_c_masked;
          r_f     <= w_f_masked;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The array's own clear follows rst_i asynchronously as well as the CLEAR state.
  assign array_rst_no  = ~rst_i & (r_state != S_CLEAR);
  assign array_start_o = r_start;
  assign n_dim_o       = r_n;
  assign k_dim_o       = r_k;
  assign m_dim_o       = r_m;
  assign c_result_o    = r_c;
  assign flags_o       = r_f;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;

endmodule

// File: tb/tb_matmul_ctrl_module.sv
// Directed bench for matmul_ctrl_module: the array is stood in for by driving
// c_matrix_i/flags_i with hand-computed products plus junk in out-of-range slots.
module tb_matmul_ctrl_module;
  localparam int DW = 8;
  localparam int BW = 16;
  localparam int SL = 4;
  localparam int CW = SL * 2 * DW;

  localparam logic [CW-1:0] C1    = 64'h0032_0016_002B_0013; // [[19,22],[43,50]]
  localparam logic [CW-1:0] C2IN  = 64'hAAAA_BBBB_CCCC_0002;
  localparam logic [CW-1:0] C2EXP = 64'h0000_0000_0000_0002;
  localparam logic [CW-1:0] CID   = 64'h0001_0000_0000_0001;
  localparam logic [CW-1:0] COVF  = 64'h8000_8000_8000_8000;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [1:0]    n, k, m;
  logic [CW-1:0] cmat;
  logic [SL-1:0] fl;
  logic          array_rst_no, array_start_o, busy_o, done_o, err_o;
  logic [1:0]    n_dim_o, k_dim_o, m_dim_o;
  logic [CW-1:0] c_result_o;
  logic [SL-1:0] flags_o;

  int n_tests = 0;
  int n_fail  = 0;

  matmul_ctrl_module #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
    .clk_i(clk), .rst_i(rst), .go_i(go),
    .n_dim_i(n), .k_dim_i(k), .m_dim_i(m),
    .c_matrix_i(cmat), .flags_i(fl),
    .array_rst_no(array_rst_no), .array_start_o(array_start_o),
    .n_dim_o(n_dim_o), .k_dim_o(k_dim_o), .m_dim_o(m_dim_o),
    .c_result_o(c_result_o), .flags_o(flags_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] nn, input logic [1:0] kk, input logic [1:0] mm);
    @(negedge clk);
    n = nn; k = kk; m = mm; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0; n = 2'd3; k = 2'd3; m = 2'd3;
  endtask

  task automatic observe(input string tag, input int exp_done, input int exp_len,
                         input logic [CW-1:0] exp_c, input logic [SL-1:0] exp_f,
                         input logic [1:0] en, input logic [1:0] ek, input logic [1:0] em,
                         input int busy_go_cyc);
    int done_cyc  = 0;
    int busy_cnt  = 0;
    int start_cnt = 0;
    int clr_cnt   = 0;
    int clr_cyc   = 0;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (array_start_o) start_cnt++;
      if (!array_rst_no) begin clr_cnt++; clr_cyc = cyc; end
      if (done_o) done_cyc = cyc;
      if (cyc == busy_go_cyc) begin
        go = 1'b1; n = 2'd1; k = 2'd1; m = 2'd1;
      end else begin
        go = 1'b0;
      end
    end
    chk_eq({tag, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
    chk_eq({tag, ".start_cycles"}, 64'(start_cnt), 64'(exp_len));
    chk_eq({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_done - 1));
    chk_eq({tag, ".clear_cycles"}, 64'(clr_cnt), 64'd1);
    chk_eq({tag, ".clear_at"}, 64'(clr_cyc), 64'd1);
    chk_eq({tag, ".c_result"}, c_result_o, exp_c);
    chk_eq({tag, ".flags"}, 64'(flags_o), 64'(exp_f));
    chk_eq({tag, ".dims"}, 64'({n_dim_o, k_dim_o, m_dim_o}), 64'({en, ek, em}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s_cnt;
    int c_cnt;
    rst = 1'b1; go = 1'b0; n = 2'd0; k = 2'd0; m = 2'd0; cmat = '0; fl = '0;
    repeat (2) @(negedge clk);
    chk_eq("rst.busy", 64'(busy_o), 64'd0);
    chk_eq("rst.done", 64'(done_o), 64'd0);
    chk_eq("rst.start", 64'(array_start_o), 64'd0);
    chk_eq("rst.err", 64'(err_o), 64'd0);
    chk_eq("rst.c_result", c_result_o, 64'd0);
    chk_eq("rst.array_rst_no", 64'(array_rst_no), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("rst.release_array_rst_no", 64'(array_rst_no), 64'd1);

    // Test 1: 2x2x2 product, with an ignored go pulse while busy
    cmat = C1; fl = '0;
    launch(2'd2, 2'd2, 2'd2);
    observe("t1", 10, 7, C1, 4'b0000, 2'd2, 2'd2, 2'd2, 4);
    @(negedge clk);
    chk_eq("t1.done_pulse", 64'(done_o), 64'd0);
    chk_eq("t1.hold", c_result_o, C1);
    chk_eq("t1.no_restart", 64'(busy_o), 64'd0);

    // Test 2: N=1,K=2,M=1 with junk in masked slots
    cmat = C2IN; fl = 4'b1111;
    launch(2'd1, 2'd2, 2'd1);
    observe("t2", 8, 5, C2EXP, 4'b0001, 2'd1, 2'd2, 2'd1, 0);

    // Test 3: back-to-back, go held through DONE is accepted only from IDLE
    cmat = C1; fl = '0;
    launch(2'd2, 2'd2, 2'd2);
    observe("t3a", 10, 7, C1, 4'b0000, 2'd2, 2'd2, 2'd2, 0);
    cmat = CID; n = 2'd2; k = 2'd2; m = 2'd2; go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_eq("t3.go_in_done_ignored", 64'(busy_o), 64'd0);
    @(posedge clk);
    #1 go = 1'b0; n = 2'd3; k = 2'd3; m = 2'd3;
    observe("t3b", 10, 7, CID, 4'b0000, 2'd2, 2'd2, 2'd2, 0);

    // Test 4: overflow flags pass through for in-range slots
    cmat = COVF; fl = 4'b1111;
    launch(2'd2, 2'd2, 2'd2);
    observe("t4", 10, 7, COVF, 4'b1111, 2'd2, 2'd2, 2'd2, 0);

    // Test 5: illegal dims raise sticky err, array untouched
    launch(2'd2, 2'd0, 2'd2);
    s_cnt = 0; c_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (array_start_o) s_cnt++;
      if (!array_rst_no) c_cnt++;
    end
    chk_eq("t5.err", 64'(err_o), 64'd1);
    chk_eq("t5.busy", 64'(busy_o), 64'd0);
    chk_eq("t5.start_cycles", 64'(s_cnt), 64'd0);
    chk_eq("t5.clear_cycles", 64'(c_cnt), 64'd0);
    chk_eq("t5.result_held", c_result_o, COVF);
    cmat = CID; fl = 4'b1111;
    launch(2'd2, 2'd2, 2'd2);
    observe("t5b", 10, 7, CID, 4'b1111, 2'd2, 2'd2, 2'd2, 0);
    chk_eq("t5.err_cleared", 64'(err_o), 64'd0);
    launch(2'd2, 2'd2, 2'd3);
    @(negedge clk);
    chk_eq("t5.err_over_max", 64'(err_o), 64'd1);
    chk_eq("t5.busy_over_max", 64'(busy_o), 64'd0);

    // Test 6: reset in the middle of RUN
    cmat = C1; fl = '0;
    launch(2'd2, 2'd2, 2'd2);
    repeat (4) @(negedge clk);
    chk_eq("t6.running", 64'(array_start_o), 64'd1);
    rst = 1'b1;
    #1;
    chk_eq("t6.busy", 64'(busy_o), 64'd0);
    chk_eq("t6.done", 64'(done_o), 64'd0);
    chk_eq("t6.start", 64'(array_start_o), 64'd0);
    chk_eq("t6.array_rst_no", 64'(array_rst_no), 64'd0);
    chk_eq("t6.c_result", c_result_o, 64'd0);
    chk_eq("t6.flags", 64'(flags_o), 64'd0);
    chk_eq("t6.err", 64'(err_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    launch(2'd2, 2'd2, 2'd2);
    observe("t6b", 10, 7, C1, 4'b0000, 2'd2, 2'd2, 2'd2, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
